// File: rtl/mini_pkg.sv
// Shared defaults and FSM encoding for the mini ROM burst reader.
package mini_pkg;
  localparam int AW_DEF = 8;
  localparam int DW_DEF = 8;
  localparam int LW_DEF = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;
endpackage

// File: rtl/mini_fifo2.sv
// Two-entry output FIFO; push and pop may happen in the same cycle.
module mini_fifo2 #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);
  logic [1:0][W-1:0] mem_q, mem_d;
  logic              wr_q, wr_d;
  logic              rd_q, rd_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              push_ok, pop_ok;

  assign pop_ok  = pop && (cnt_q != 2'd0);
  assign push_ok = push && ((cnt_q != 2'd2) || pop_ok);

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (push_ok) begin
      mem_d[wr_q] = din;
      wr_d        = ~wr_q;
    end
    if (pop_ok) rd_d = ~rd_q;
    cnt_d = cnt_q + 2'(push_ok) - 2'(pop_ok);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q <= '0;
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign dout  = mem_q[rd_q];
  assign count = cnt_q;
endmodule

// File: rtl/mini_rom.sv
// Small registered lookup ROM: 0x00-0x0F -> x0A..xFA, 0x10-0x1F -> 0x50..0x5F, else 0xFF.
module mini_rom (
  input  logic       clk,
  input  logic [7:0] addr,
  output logic [7:0] dout
);
  logic [7:0] rd_d;

  always_comb begin
    rd_d = 8'hFF;
    case (addr[7:4])
      4'h0:    rd_d = {addr[3:0], 4'hA};
      4'h1:    rd_d = {4'h5, addr[3:0]};
      default: rd_d = 8'hFF;
    endcase
  end

  always_ff @(posedge clk) dout <= rd_d;
endmodule

// File: rtl/mini_rom_reader.sv
// Burst reader: issues sequential ROM reads and streams the data out through a
// 2-deep FIFO with valid/ready backpressure.
module mini_rom_reader
  import mini_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int LW = LW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [LW-1:0] length,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_dout,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_last
);
  state_t        state_q, state_d;
  logic [AW-1:0] base_q, base_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          infl_q, infl_d;
  logic          infl_last_q, infl_last_d;
  logic          done_q, done_d;

  logic          pop, issue, issue_last;
  logic [2:0]    pending;
  logic [AW-1:0] issue_addr;
  logic [1:0]    fifo_cnt;
  logic [DW:0]   fifo_dout;

  assign pop        = m_valid && m_ready;
  // Beats that will still occupy the FIFO next cycle, before this cycle's issue.
  assign pending    = {1'b0, fifo_cnt} + {2'b00, infl_q} - {2'b00, pop};
  assign issue      = (state_q == RUN) && (pending <= 3'd1);
  assign issue_addr = base_q + AW'(cnt_q);
  assign issue_last = (cnt_q == len_q - LW'(1));

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    infl_d      = issue;
    infl_last_d = issue && issue_last;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          base_d  = base_addr;
          len_d   = length;
          cnt_d   = '0;
          state_d = (length == '0) ? DRAIN : RUN;
        end
      end
      RUN: begin
        if (issue) begin
          cnt_d  = cnt_q + LW'(1);
          addr_d = issue_addr;
          if (issue_last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Finish in the cycle the final beat leaves, so done follows it directly.
        if (!infl_q && ((fifo_cnt == 2'd0) || ((fifo_cnt == 2'd1) && pop))) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      base_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      addr_q      <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      infl_q      <= infl_d;
      infl_last_q <= infl_last_d;
      done_q      <= done_d;
    end
  end

  mini_fifo2 #(.W(DW + 1)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (infl_q),
    .din   ({infl_last_q, rom_dout}),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (fifo_cnt)
  );

  assign rom_addr = issue ? issue_addr : addr_q;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign m_valid  = (fifo_cnt != 2'd0);
  assign m_data   = fifo_dout[DW-1:0];
  assign m_last   = fifo_dout[DW];
endmodule

// File: doc/mini_rom_reader.md
MINI_ROM_READER -- requirements
Module: mini_rom_reader

Interface
REQ-001 The block SHALL take parameter AW, default 8, meaning the ROM address width.
REQ-002 The block SHALL take parameter DW, default 8, meaning the ROM data width.
REQ-003 The block SHALL take parameter LW, default 9, meaning the burst-length width (a length of 256 is legal).
REQ-004 The block SHALL have ports, in this order:
- clk  in  1  the single clock; all logic on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle burst request.
- base_addr  in  AW  first ROM address of the burst.
- length  in  LW  number of beats in the burst.
- busy  out  1  a burst is in progress.
- done  out  1  one-cycle pulse when a burst completes.
- rom_addr  out  AW  address to the mini_rom addr port.
- rom_dout  in  DW  data from mini_rom dout; valid one cycle after rom_addr is sampled.
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream accepts the beat.
- m_data  out  DW  output beat data.
- m_last  out  1  marks the final beat of the burst.

Function
REQ-005 The FSM SHALL have three states: IDLE, RUN and DRAIN.
REQ-006 In IDLE, start=1 SHALL latch base_addr and length, clear the issue counter, and move to RUN; busy=1 from the next cycle.
REQ-007 start SHALL be ignored while busy=1.
REQ-008 start with length=0 SHALL move to DRAIN, produce no beats, and pulse done 2 cycles after start.
REQ-009 Beat i SHALL read address (base_addr+i) mod 2^AW; wrap from 0xFF to 0x00 is legal.
REQ-010 An issue SHALL occur in a cycle only if (FIFO occupancy + in-flight reads − current pop) ≤ 1.
- In-flight reads: issued last cycle, not yet captured.
- Current pop: m_valid && m_ready.
REQ-011 rom_dout SHALL be captured into the output FIFO exactly one cycle after its issue, tagged with last = (i == length−1).
REQ-012 With m_ready held at 1, the block SHALL sustain one beat per cycle.
REQ-013 With m_ready held at 1, the first m_valid SHALL appear 3 cycles after the start edge.
REQ-014 When the last address has issued, the FSM SHALL go RUN→DRAIN.
REQ-015 In DRAIN, once the FIFO and the in-flight read are both empty, the FSM SHALL go to IDLE. In that same cycle done=1 and busy=0.
REQ-016 While m_valid=1 && m_ready=0, m_data and m_last SHALL hold stable; no beat may be lost or duplicated.
REQ-017 m_valid SHALL be 1 exactly when the FIFO is non-empty.
REQ-018 rom_addr SHALL hold its last value when not issuing.
REQ-019 Data SHALL pass through unmodified, including 0xFF returned for unmapped addresses.
REQ-020 rom_dout SHALL NOT be sampled for anything other than a read issued in the previous cycle.

Reset
REQ-021 rst_n=0 at a clock edge SHALL force IDLE, with busy=0, done=0, m_valid=0, m_last=0, m_data=0 and rom_addr=0.
REQ-022 That reset SHALL also empty the FIFO and clear the in-flight flag and counters.
REQ-023 Reset mid-burst SHALL discard all pending and in-flight data; no beat may appear after reset release until a new start.

Structure
REQ-024 The shared package mini_pkg SHALL hold the AW/DW defaults and the FSM state enum.
REQ-025 Output buffering SHALL be a sub-module mini_fifo2: 2 entries, DW+1 bits wide, with push, pop, occupancy count, and simultaneous push+pop supported.
REQ-026 The bench SHALL connect the block to a mini_rom instance with these contents:
- 0x00–0x0F = 0x0A,0x1A,…,0xFA.
- 0x10–0x1F = 0x50–0x5F.
- All other addresses = 0xFF.

Verification
REQ-027 base=0x00, len=4, m_ready=1 → m_data 0A,1A,2A,3A on consecutive cycles from start+3; m_last on 3A; done the next cycle.
REQ-028 base=0xFE, len=4 → FF,FF,0A,1A; rom_addr sequence FE,FF,00,01.
REQ-029 base=0x10, len=16, m_ready random at 50% → exactly 50..5F in order, with m_data stable during every stall and m_last only on 5F.
REQ-030 len=0 → no m_valid; done pulse at start+2; a start pulse during a len=8 burst is ignored (exactly 8 beats).
REQ-031 rst_n low for 1 cycle at beat 3 of base=0x00, len=16 → all outputs zero next cycle; no further beats.
REQ-032 A new burst base=0x10, len=2 after that reset → exactly 50,51.
